// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer shared by the pipeline Memory stage (m_) and
// the program loader / debug port (ld_). One access is in flight at a time:
// the winning request is range-checked, issued to a fixed-latency synchronous
// RAM as a single ram_en pulse, and answered with a one-cycle done pulse on
// the requesting port. Out-of-range addresses never reach the RAM.
module dmem_access_ctrl #(
  parameter int MEM_WORDS = 8192,
  parameter int AW        = 13,
  parameter int RD_LAT    = 2
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m_req,
  input  logic          m_write,
  input  logic [63:0]   m_addr,
  input  logic [63:0]   m_wdata,
  output logic [63:0]   m_rdata,
  output logic          m_done,
  output logic          m_err,
  output logic          m_stall,

  input  logic          ld_req,
  input  logic          ld_write,
  input  logic [63:0]   ld_addr,
  input  logic [63:0]   ld_wdata,
  output logic [63:0]   ld_rdata,
  output logic          ld_done,
  output logic          ld_err,

  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [63:0]   ram_wdata,
  input  logic [63:0]   ram_rdata
);

  localparam logic [63:0] MEM_LIMIT = 64'(MEM_WORDS);
  localparam logic [3:0]  LAT_LOAD  = 4'(RD_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {PORT_M = 1'b0, PORT_LD = 1'b1} port_t;

  state_t     state_q, state_d;
  // The most recent grant is also the port that owns the access in flight.
  port_t      last_grant_q;
  logic       wr_q;
  logic [3:0] cnt_q;

  logic        grant_valid;
  port_t       grant_port;
  logic        grant_write;
  logic [63:0] grant_addr;
  logic [63:0] grant_wdata;
  logic        grant_err;
  logic        last_wait;

  logic          ram_en_d;
  logic          ram_we_d;
  logic [AW-1:0] ram_addr_d;
  logic [63:0]   ram_wdata_d;
  logic          resp_fire;
  port_t         resp_port;
  logic          resp_err;
  logic [63:0]   resp_data;

  // Arbitrate in IDLE: a lone request wins, a tie goes to the port not served last.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // it unassigned and no latch is inferred.
    grant_port = PORT_M;
    if (m_req && ld_req) begin
      grant_port = (last_grant_q == PORT_M) ? PORT_LD : PORT_M;
    end else if (ld_req) begin
      grant_port = PORT_LD;
    end
    grant_valid = (state_q == S_IDLE) && (m_req || ld_req);
    grant_write = (grant_port == PORT_LD) ? ld_write : m_write;
    grant_addr  = (grant_port == PORT_LD) ? ld_addr  : m_addr;
    grant_wdata = (grant_port == PORT_LD) ? ld_wdata : m_wdata;
    // Full-width compare: high address bits must not alias into the array.
    grant_err   = (grant_addr >= MEM_LIMIT);
    last_wait   = (state_q == S_WAIT) && (cnt_q == 4'd1);
  end

  // State register; reset abandons any access in progress.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples the values present before the edge.
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: error grants skip the RAM and answer immediately.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_valid) state_d = grant_err ? S_RESP : S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered outputs, so each one is high
  // exactly during the ISSUE or RESP cycle it belongs to.
  always_comb begin
    ram_en_d    = grant_valid && !grant_err;
    ram_we_d    = ram_en_d && grant_write;
    ram_addr_d  = ram_en_d ? grant_addr[AW-1:0] : '0;
    ram_wdata_d = ram_en_d ? grant_wdata : '0;
    resp_fire   = (grant_valid && grant_err) || last_wait;
    resp_port   = grant_valid ? grant_port : last_grant_q;
    resp_err    = grant_valid;
    resp_data   = (last_wait && !wr_q) ? ram_rdata : '0;
  end

  // Output registers; the idle port and all data outputs rest at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      m_done    <= 1'b0;
      m_err     <= 1'b0;
      m_rdata   <= '0;
      ld_done   <= 1'b0;
      ld_err    <= 1'b0;
      ld_rdata  <= '0;
    end else begin
      ram_en    <= ram_en_d;
      ram_we    <= ram_we_d;
      ram_addr  <= ram_addr_d;
      ram_wdata <= ram_wdata_d;
      m_done    <= resp_fire && (resp_port == PORT_M);
      m_err     <= resp_fire && (resp_port == PORT_M) && resp_err;
      m_rdata   <= (resp_fire && (resp_port == PORT_M)) ? resp_data : '0;
      ld_done   <= resp_fire && (resp_port == PORT_LD);
      ld_err    <= resp_fire && (resp_port == PORT_LD) && resp_err;
      ld_rdata  <= (resp_fire && (resp_port == PORT_LD)) ? resp_data : '0;
    end
  end

  // Grant bookkeeping and the read-latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= PORT_LD;
      wr_q         <= 1'b0;
      cnt_q        <= '0;
    end else begin
      if (grant_valid) begin
        last_grant_q <= grant_port;
        wr_q         <= grant_write;
      end
      if (state_q == S_ISSUE) begin
        cnt_q <= LAT_LOAD;
      end else if (state_q == S_WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // The pipeline holds its M register until its own done pulse.
  assign m_stall = m_req & ~m_done;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, reset-abort and
// arbitration sequences, randomized two-port traffic scored against an
// access-level model, and an RD_LAT=1 instance for latency/throughput.
module tb_dmem_access_ctrl;

  localparam int MEM_WORDS = 8192;
  localparam int AW        = 13;
  localparam int LAT       = 2;

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    bit          done;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } obs_t;

  typedef struct {
    bit          use_ld;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  typedef enum bit {P_M, P_LD} pid_t;

  int total = 0;
  int bad   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (RD_LAT = 2)
  logic          m_req = 0, m_write = 0;
  logic [63:0]   m_addr = '0, m_wdata = '0;
  logic [63:0]   m_rdata;
  logic          m_done, m_err, m_stall;
  logic          ld_req = 0, ld_write = 0;
  logic [63:0]   ld_addr = '0, ld_wdata = '0;
  logic [63:0]   ld_rdata;
  logic          ld_done, ld_err;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [63:0]   ram_wdata, ram_rdata;

  // Second instance (RD_LAT = 1), Memory-stage port only
  logic          u1_m_req = 0, u1_m_write = 0;
  logic [63:0]   u1_m_addr = '0, u1_m_wdata = '0;
  logic [63:0]   u1_m_rdata, u1_ld_rdata;
  logic          u1_m_done, u1_m_err, u1_m_stall, u1_ld_done, u1_ld_err;
  logic          u1_ram_en, u1_ram_we;
  logic [AW-1:0] u1_ram_addr;
  logic [63:0]   u1_ram_wdata, u1_ram_rdata;

  dmem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .AW(AW), .RD_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done), .m_err(m_err), .m_stall(m_stall),
    .ld_req(ld_req), .ld_write(ld_write), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_done(ld_done), .ld_err(ld_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  dmem_access_ctrl #(.MEM_WORDS(MEM_WORDS), .AW(AW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .m_req(u1_m_req), .m_write(u1_m_write), .m_addr(u1_m_addr), .m_wdata(u1_m_wdata),
    .m_rdata(u1_m_rdata), .m_done(u1_m_done), .m_err(u1_m_err), .m_stall(u1_m_stall),
    .ld_req(1'b0), .ld_write(1'b0), .ld_addr(64'd0), .ld_wdata(64'd0),
    .ld_rdata(u1_ld_rdata), .ld_done(u1_ld_done), .ld_err(u1_ld_err),
    .ram_en(u1_ram_en), .ram_we(u1_ram_we), .ram_addr(u1_ram_addr), .ram_wdata(u1_ram_wdata),
    .ram_rdata(u1_ram_rdata)
  );

  function automatic logic [63:0] init_val(input int i);
    return (i == 5) ? 64'h0000_0000_DEAD_BEEF : {32'hA0A0_0000, 32'(i)};
  endfunction

  function automatic logic [63:0] u1_pattern(input logic [AW-1:0] a);
    return 64'hFEED_0000_0000_0000 | 64'(a);
  endfunction

  // RAM for the main instance: two-stage read pipe, garbage when not valid.
  logic [63:0] mem [MEM_WORDS];
  logic        mem_init = 1'b0;
  logic [63:0] rd_d0, rd_d1, junk;
  logic        rd_v0 = 1'b0, rd_v1 = 1'b0;
  always @(posedge clk) begin
    junk  <= {$urandom, $urandom};
    rd_v0 <= ram_en && !ram_we;
    rd_d0 <= mem[ram_addr];
    rd_v1 <= rd_v0;
    rd_d1 <= rd_d0;
    if (mem_init) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= init_val(i);
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = rd_v1 ? rd_d1 : junk;

  // Read-only pattern RAM for the RD_LAT=1 instance.
  logic        u1_v = 1'b0;
  logic [63:0] u1_d;
  always @(posedge clk) begin
    u1_v <= u1_ram_en && !u1_ram_we;
    u1_d <= u1_pattern(u1_ram_addr);
  end
  assign u1_ram_rdata = u1_v ? u1_d : junk;

  // Reference model state
  logic [63:0] ref_mem [MEM_WORDS];
  pid_t        last_served;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One access as the specification describes it, applied to the model memory.
  task automatic model_access(input req_t r, output logic [63:0] rd, output logic err,
                              output int lat);
    err = (r.addr >= 64'(MEM_WORDS));
    rd  = '0;
    lat = err ? 1 : LAT + 2;
    if (!err) begin
      if (r.wr) ref_mem[r.addr[AW-1:0]] = r.wdata;
      else      rd = ref_mem[r.addr[AW-1:0]];
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    int   k;
    k       = int'($urandom_range(0, 9));
    r.wr    = 1'($urandom_range(0, 1));
    r.wdata = {$urandom, $urandom};
    if (k < 5)       r.addr = 64'($urandom_range(0, 15));
    else if (k < 8)  r.addr = 64'(MEM_WORDS - 1 - int'($urandom_range(0, 7)));
    else if (k == 8) r.addr = 64'(MEM_WORDS + int'($urandom_range(0, 3)));
    else             r.addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    return r;
  endfunction

  // Drive one or both ports from an IDLE negedge; each requester drops its
  // req in its done cycle. Returns per-port observations and RAM strobe info.
  task automatic run_txn(input bit m_en, input bit l_en, input req_t mr, input req_t lr,
                         output obs_t mo, output obs_t lo, output int en_n,
                         output logic en_we, output int en_cyc);
    bit mp, lp, proto_ok;
    int cyc;
    mo = '{done: 1'b0, rdata: '0, err: 1'b0, cyc: 0};
    lo = '{done: 1'b0, rdata: '0, err: 1'b0, cyc: 0};
    m_req = m_en; m_write = mr.wr; m_addr = mr.addr; m_wdata = mr.wdata;
    ld_req = l_en; ld_write = lr.wr; ld_addr = lr.addr; ld_wdata = lr.wdata;
    mp = m_en; lp = l_en; cyc = 0; en_n = 0; en_we = 1'b0; en_cyc = 0; proto_ok = 1'b1;
    while ((mp || lp) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (ram_en) begin en_n++; en_we = ram_we; en_cyc = cyc; end
      if (m_stall !== (mp && !m_done)) proto_ok = 1'b0;
      if (!m_done && (m_rdata !== '0 || m_err !== 1'b0)) proto_ok = 1'b0;
      if (!ld_done && (ld_rdata !== '0 || ld_err !== 1'b0)) proto_ok = 1'b0;
      if (m_done && ld_done) proto_ok = 1'b0;
      if (m_done) begin
        if (!mp) proto_ok = 1'b0;
        mo = '{done: 1'b1, rdata: m_rdata, err: m_err, cyc: cyc};
        mp = 1'b0; m_req = 1'b0;
      end
      if (ld_done) begin
        if (!lp) proto_ok = 1'b0;
        lo = '{done: 1'b1, rdata: ld_rdata, err: ld_err, cyc: cyc};
        lp = 1'b0; ld_req = 1'b0;
      end
    end
    check("txn_timeout", 64'(mp || lp), 64'd0);
    @(negedge clk);
    if (m_done || ld_done || ram_en) proto_ok = 1'b0;
    check("txn_protocol", 64'(proto_ok), 64'd1);
  endtask

  // Run a transaction and score it against the model, including grant order.
  task automatic run_and_score(input bit me, input bit le, input req_t mr, input req_t lr,
                               input string tag);
    obs_t        mo, lo, fo, so;
    int          en_n, en_cyc, l1, l2, exp_en;
    logic        en_we, e1, e2;
    logic [63:0] rd1, rd2;
    pid_t        first, second;
    run_txn(me, le, mr, lr, mo, lo, en_n, en_we, en_cyc);
    if (me && le) first = (last_served == P_LD) ? P_M : P_LD;
    else          first = me ? P_M : P_LD;
    second = (first == P_M) ? P_LD : P_M;
    model_access((first == P_M) ? mr : lr, rd1, e1, l1);
    exp_en = e1 ? 0 : 1;
    fo = (first == P_M) ? mo : lo;
    check({tag, "_first_done"}, 64'(fo.done), 64'd1);
    check({tag, "_first_cycle"}, 64'(fo.cyc), 64'(l1));
    check({tag, "_first_rdata"}, fo.rdata, rd1);
    check({tag, "_first_err"}, 64'(fo.err), 64'(e1));
    if (me && le) begin
      model_access((second == P_M) ? mr : lr, rd2, e2, l2);
      exp_en += e2 ? 0 : 1;
      so = (second == P_M) ? mo : lo;
      check({tag, "_second_cycle"}, 64'(so.cyc), 64'(l1 + 1 + l2));
      check({tag, "_second_rdata"}, so.rdata, rd2);
      check({tag, "_second_err"}, 64'(so.err), 64'(e2));
      last_served = second;
    end else begin
      last_served = first;
    end
    check({tag, "_ram_en_count"}, 64'(en_n), 64'(exp_en));
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [10];
    obs_t        mo, lo, o;
    int          en_n, en_cyc, cyc, n_en, n_done;
    int          en_at [3];
    logic        en_we, seen, got, ok1;
    logic [63:0] rd;
    req_t        r;

    // use_ld, wr, addr, wdata, exp_rdata, exp_err, exp_lat, exp_en
    vecs[0] = '{1'b0, 1'b0, 64'd5,                  64'd0,              64'h0000_0000_DEAD_BEEF, 1'b0, 4, 1};
    vecs[1] = '{1'b0, 1'b1, 64'd7,                  64'h1234,           64'd0,                   1'b0, 4, 1};
    vecs[2] = '{1'b0, 1'b0, 64'd7,                  64'd0,              64'h1234,                1'b0, 4, 1};
    vecs[3] = '{1'b0, 1'b0, 64'd8192,               64'd0,              64'd0,                   1'b1, 1, 0};
    vecs[4] = '{1'b0, 1'b0, 64'hFFFF_0000_0000_0005, 64'd0,             64'd0,                   1'b1, 1, 0};
    vecs[5] = '{1'b0, 1'b1, 64'd8192,               64'h0BAD,           64'd0,                   1'b1, 1, 0};
    vecs[6] = '{1'b1, 1'b0, 64'd0,                  64'd0,              64'hA0A0_0000_0000_0000, 1'b0, 4, 1};
    vecs[7] = '{1'b1, 1'b1, 64'd8191,               64'h5555_AAAA,      64'd0,                   1'b0, 4, 1};
    vecs[8] = '{1'b1, 1'b0, 64'd8191,               64'd0,              64'h5555_AAAA,           1'b0, 4, 1};
    vecs[9] = '{1'b1, 1'b0, 64'h0000_0001_0000_0007, 64'd0,             64'd0,                   1'b1, 1, 0};

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_val(i);
    rst = 1'b1;
    mem_init = 1'b1;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    check("reset_ctrl_outs", 64'({ram_en, ram_we, m_done, m_err, m_stall, ld_done, ld_err, ram_addr}), 64'd0);
    check("reset_data_outs", m_rdata | ld_rdata | ram_wdata, 64'd0);
    rst = 1'b0;
    last_served = P_LD;
    @(negedge clk);

    // Directed single-port vectors
    for (int i = 0; i < 10; i++) begin
      r = '{wr: vecs[i].wr, addr: vecs[i].addr, wdata: vecs[i].wdata};
      run_txn(!vecs[i].use_ld, vecs[i].use_ld, r, r, mo, lo, en_n, en_we, en_cyc);
      o = vecs[i].use_ld ? lo : mo;
      check($sformatf("vec%0d_done", i), 64'(o.done), 64'd1);
      check($sformatf("vec%0d_rdata", i), o.rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 64'(o.err), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 64'(o.cyc), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_ram_en_count", i), 64'(en_n), 64'(vecs[i].exp_en));
      if (vecs[i].exp_en != 0) begin
        check($sformatf("vec%0d_ram_en_cycle", i), 64'(en_cyc), 64'd1);
        check($sformatf("vec%0d_ram_we", i), 64'(en_we), 64'(vecs[i].wr));
      end
      if (vecs[i].wr && !vecs[i].exp_err) ref_mem[vecs[i].addr[AW-1:0]] = vecs[i].wdata;
      last_served = vecs[i].use_ld ? P_LD : P_M;
    end

    // Reset during the WAIT phase of a read
    m_req = 1'b1; m_write = 1'b0; m_addr = 64'd5;
    @(negedge clk);
    check("abort_issue_ram_en", 64'(ram_en), 64'd1);
    @(negedge clk);
    rst = 1'b1; m_req = 1'b0;
    #1;
    check("abort_ctrl_outs", 64'({ram_en, ram_we, m_done, m_err, ld_done, ld_err, ram_addr}), 64'd0);
    check("abort_data_outs", m_rdata | ld_rdata | ram_wdata, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_served = P_LD;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (m_done || ld_done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    // Both ports after reset: pipeline wins the first tie, then alternation
    run_and_score(1'b1, 1'b1, '{1'b0, 64'd5, 64'd0}, '{1'b0, 64'd7, 64'd0}, "rr_a");
    run_and_score(1'b1, 1'b1, '{1'b1, 64'd9, 64'h99}, '{1'b0, 64'd9, 64'd0}, "rr_b");
    run_and_score(1'b1, 1'b0, '{1'b0, 64'd9, 64'd0}, '{1'b0, 64'd0, 64'd0}, "post_rst_read");

    // Randomized traffic on one or both ports
    for (int it = 0; it < 120; it++) begin
      int   pick;
      req_t mr, lr;
      pick = int'($urandom_range(0, 2));
      mr = rand_req();
      lr = rand_req();
      run_and_score(pick != 1, pick != 0, mr, lr, "rnd");
    end

    // RD_LAT = 1 instance: latency of a single read
    u1_m_req = 1'b1; u1_m_write = 1'b0; u1_m_addr = 64'd0;
    cyc = 0; got = 1'b0; rd = '0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (u1_m_done) begin got = 1'b1; rd = u1_m_rdata; u1_m_req = 1'b0; end
    end
    check("lat1_done_cycle", 64'(cyc), 64'd3);
    check("lat1_rdata", rd, u1_pattern(13'd0));
    @(negedge clk);

    // RD_LAT = 1 instance: request held across three accesses
    u1_m_addr = 64'd3; u1_m_req = 1'b1;
    cyc = 0; n_en = 0; n_done = 0; ok1 = 1'b1;
    en_at[0] = 0; en_at[1] = 0; en_at[2] = 0;
    while (n_done < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (u1_ram_en) begin
        if (n_en < 3) en_at[n_en] = cyc;
        n_en++;
      end
      if (u1_ram_we || u1_ram_wdata !== '0 || u1_ld_done || u1_ld_err || u1_ld_rdata !== '0) ok1 = 1'b0;
      if (u1_m_stall !== (u1_m_req && !u1_m_done)) ok1 = 1'b0;
      if (u1_m_done) begin
        n_done++;
        if (u1_m_rdata !== u1_pattern(13'd3) || u1_m_err) ok1 = 1'b0;
        if (n_done == 3) u1_m_req = 1'b0;
      end
    end
    check("lat1_b2b_dones", 64'(n_done), 64'd3);
    check("lat1_b2b_ram_en_count", 64'(n_en), 64'd3);
    check("lat1_b2b_first_en", 64'(en_at[0]), 64'd1);
    check("lat1_b2b_gap1", 64'(en_at[1] - en_at[0]), 64'd4);
    check("lat1_b2b_gap2", 64'(en_at[2] - en_at[1]), 64'd4);
    check("lat1_b2b_protocol", 64'(ok1), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences and shares the single data-memory array between two requesters: the pipeline Memory stage (port m_) and the program loader/debug port (port ld_).
- Issues one-cycle enable pulses to a fixed-latency synchronous RAM and waits the read latency.
- Returns read data, a done pulse and an address-error flag. Drives m_stall so the pipeline holds its M register while an access is outstanding.

Parameters:
- MEM_WORDS, 8192, number of 64-bit words; any address >= MEM_WORDS is an address error.
- AW, 13, RAM word-address width; must satisfy 2**AW >= MEM_WORDS.
- RD_LAT, 2, RAM cycles from the ram_en edge to valid ram_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- m_req  in  1  Memory-stage access request; held until m_done.
- m_write  in  1  1 = write, 0 = read.
- m_addr  in  64  word address.
- m_wdata  in  64  write data.
- m_rdata  out  64  read data; valid while m_done is high.
- m_done  out  1  one-cycle completion pulse.
- m_err  out  1  address error; valid with m_done.
- m_stall  out  1  combinational: m_req & ~m_done.
- ld_req, ld_write, ld_addr, ld_wdata, ld_rdata, ld_done, ld_err  same widths and meaning as the m_ signals, for the loader port.
- ram_en  out  1  one-cycle access strobe.
- ram_we  out  1  write enable; qualified by ram_en.
- ram_addr  out  AW  word address (m_addr/ld_addr[AW-1:0]).
- ram_wdata  out  64  write data.
- ram_rdata  in  64  read data; valid RD_LAT cycles after ram_en.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered except m_stall.
- Reset values: state IDLE, last_grant=LD, cnt=0, all outputs 0.
- IDLE:
  - Samples m_req and ld_req at each edge. No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not equal to last_grant (round-robin). After reset the pipeline wins the first tie.
  - On grant: latch sel, write, addr, wdata; update last_grant.
  - Granted addr >= MEM_WORDS (full 64-bit compare): go to RESP with err=1 and rdata=0. No ram_en is issued and memory is unchanged.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - ram_en=1, ram_we=latched write, ram_addr and ram_wdata from the latched fields.
  - Load cnt=RD_LAT, go to WAIT.
- WAIT:
  - ram_en=0; decrement cnt each cycle.
  - When cnt reaches 1, capture ram_rdata on that edge (reads only; writes capture 0) and go to RESP.
  - WAIT lasts exactly RD_LAT cycles.
- RESP (1 cycle):
  - Assert done and err for sel only, with rdata for sel; the other port's outputs stay 0.
  - Go to IDLE.
- Latency: request sampled at edge E. In-range access: done high in cycle E+RD_LAT+2 (4 cycles for RD_LAT=2). Error access: done in cycle E+1.
- Reads and writes have identical timing.
- Requester rules:
  - Hold req and all fields stable until done.
  - Deassert req at the edge ending the done cycle. A req still high in the following IDLE cycle is a new request.
- Non-granted requester waits with no loss of its request; fairness guarantees service within one other access.
- m_rdata/ld_rdata hold 0 outside done.
- Only one access is outstanding at any time; no pipelining of requests.
- rst asserted mid-access: immediately return to IDLE, ram_en=0, no done pulse. An in-flight RAM write that already saw ram_en is not undone.

Test Plan:
- Preload word 5=0xDEAD_BEEF; m_req read addr 5 at edge 0 -> ram_en in cycle 1 only; m_done=1, m_rdata=0xDEADBEEF, m_err=0 in cycle 4; m_stall high cycles 0-3.
- m write addr 7 data 0x1234, then m read addr 7 -> ram_we=1 with ram_en in cycle 1; second access returns 0x1234; ld_done stays 0 throughout.
- m read addr 8192 and addr 0xFFFF_0000_0000_0005 -> m_done=1, m_err=1, m_rdata=0 one cycle after sampling; ram_en never asserted.
- m_req and ld_req both raised after reset and held for three accesses -> grants in order M, LD, M; each requester sees exactly one done per access.
- Assert rst in the WAIT cycle of a read -> state IDLE, all outputs 0, no m_done; a new read after reset release completes with the normal 4-cycle latency.
- RD_LAT=1 build: read addr 0 -> done in cycle 3; back-to-back requests issue ram_en every 4 cycles.
